// File: rtl/capture_pkg.sv
// Shared types and defaults for the ADC capture path (writer, RAM wrapper, readout).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package capture_pkg;

  localparam int               CAP_DATA_W    = 16;
  localparam int               CAP_ADDR_W    = 12;
  localparam int               CAP_CLKDIV    = 4;
  localparam logic [15:0]      CAP_SYNC_WORD = 16'hA5C3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/readout_bit_timer.sv
// Bit-period divider and bit index for the serial readout; drives the registered TX clock phase.
// Latency: load takes effect next cycle (divider 0, bit DATA_W-1, tx_clk low).
// Backpressure: none; free-runs while i_run, stop/reset clear everything.
module readout_bit_timer #(
  parameter int DATA_W = 16,
  parameter int CLKDIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_run,
  input  logic i_stop,
  output logic o_bit_end,
  output logic o_last_bit_next,
  output logic o_word_end,
  output logic o_tx_clk
);

  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKDIV / 2);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(DATA_W - 1);

  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  logic             r_tx_clk;
  logic [DIV_W-1:0] w_div_nxt;

  assign w_div_nxt = r_div + 1'b1;

  // Divider and bit index; tx_clk is registered from the next divider value so it is glitch-free
  always_ff @(posedge i_clk) begin
    if (i_rst || i_stop) begin
      r_div    <= '0;
      r_bit    <= '0;
      r_tx_clk <= 1'b0;
    end else if (i_load) begin
      r_div    <= '0;
      r_bit    <= BIT_MSB;
      r_tx_clk <= 1'b0;
    end else if (i_run) begin
      if (r_div == DIV_LAST) begin
        r_div    <= '0;
        r_bit    <= (r_bit == '0) ? BIT_MSB : r_bit - 1'b1;
        r_tx_clk <= 1'b0;
      end else begin
        r_div    <= w_div_nxt;
        r_tx_clk <= (w_div_nxt >= DIV_HALF);
      end
    end
  end

  // Last cycle of a bit; next cycle starts a new bit period
  assign o_bit_end       = i_run && (r_div == DIV_LAST);
  // Next cycle is the first cycle of the word's last bit (read-issue point)
  assign o_last_bit_next = o_bit_end && (r_bit == BIT_W'(1));
  assign o_word_end      = o_bit_end && (r_bit == '0);
  assign o_tx_clk        = r_tx_clk;

endmodule

// File: rtl/capture_readout_tx.sv
// Capture-RAM readout: reads WORD_CNT words and serialises sync header + data MSB-first with bit clock/frame.
// Latency: START in cycle 0 -> frame, first header bit and first RAM read in cycle 1.
// Backpressure: none; RAM answers in fixed 1 cycle, START ignored while busy, ABORT ends transfer next cycle.
module capture_readout_tx
  import capture_pkg::*;
#(
  parameter int                DATA_W    = CAP_DATA_W,
  parameter int                ADDR_W    = CAP_ADDR_W,
  parameter int                CLKDIV    = CAP_CLKDIV,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(CAP_SYNC_WORD)
) (
  input  logic              i_clk200m,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_word_cnt,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_tx_clk,
  output logic              o_tx_data,
  output logic              o_tx_frame,
  output logic              o_busy,
  output logic              o_done
);

  state_t              r_state;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_rd_vld;
  logic [DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]   r_shift;
  logic [ADDR_W:0]     r_rd_left;
  logic [ADDR_W:0]     r_words_left;
  logic                r_tx_data;
  logic                r_frame;
  logic                r_busy;
  logic                r_done;

  logic                w_active;
  logic                w_accept;
  logic                w_bit_end;
  logic                w_last_bit_next;
  logic                w_word_end;
  logic [DATA_W-1:0]   w_next_word;

  assign w_active = (r_state == ST_HDR) || (r_state == ST_DATA);
  assign w_accept = (r_state == ST_IDLE) && i_start && !i_abort && (i_word_cnt != '0);
  // Bypass the hold register when the read data arrives on the very cycle the shifter reloads (CLKDIV=2)
  assign w_next_word = r_rd_vld ? i_rd_data : r_hold;

  readout_bit_timer #(
    .DATA_W (DATA_W),
    .CLKDIV (CLKDIV)
  ) u_bit_timer (
    .i_clk           (i_clk200m),
    .i_rst           (i_rst),
    .i_load          (w_accept),
    .i_run           (w_active),
    .i_stop          (i_abort),
    .o_bit_end       (w_bit_end),
    .o_last_bit_next (w_last_bit_next),
    .o_word_end      (w_word_end),
    .o_tx_clk        (o_tx_clk)
  );

  // Transfer FSM with read scheduling, hold register, shifter and registered outputs
  always_ff @(posedge i_clk200m) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_vld     <= 1'b0;
      r_hold       <= '0;
      r_shift      <= '0;
      r_rd_left    <= '0;
      r_words_left <= '0;
      r_tx_data    <= 1'b0;
      r_frame      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_rd_en  <= 1'b0;
      r_done   <= 1'b0;
      r_rd_vld <= r_rd_en;
      if (r_rd_vld) r_hold <= i_rd_data;

      if (i_abort) begin
        r_state   <= ST_IDLE;
        r_tx_data <= 1'b0;
        r_frame   <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              if (i_word_cnt == '0) begin
                r_state <= ST_FIN;
                r_done  <= 1'b1;
              end else begin
                r_state      <= ST_HDR;
                r_busy       <= 1'b1;
                r_frame      <= 1'b1;
                r_shift      <= SYNC_WORD;
                r_tx_data    <= SYNC_WORD[DATA_W-1];
                r_rd_en      <= 1'b1;
                r_rd_addr    <= i_base_addr;
                r_rd_left    <= i_word_cnt - 1'b1;
                r_words_left <= i_word_cnt;
              end
            end
          end
          ST_HDR, ST_DATA: begin
            if (w_word_end) begin
              if (r_words_left != '0) begin
                r_state      <= ST_DATA;
                r_shift      <= w_next_word;
                r_tx_data    <= w_next_word[DATA_W-1];
                r_words_left <= r_words_left - 1'b1;
              end else begin
                r_state   <= ST_FIN;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
                r_frame   <= 1'b0;
                r_tx_data <= 1'b0;
              end
            end else if (w_bit_end) begin
              r_shift   <= r_shift << 1;
              r_tx_data <= r_shift[DATA_W-2];
            end
            // Word k+1 is fetched during the last bit of data word k; word 0 was fetched at START
            if ((r_state == ST_DATA) && w_last_bit_next && (r_rd_left != '0)) begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= r_rd_addr + 1'b1;
              r_rd_left <= r_rd_left - 1'b1;
            end
          end
          ST_FIN: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_rd_en    = r_rd_en;
  assign o_rd_addr  = r_rd_addr;
  assign o_tx_data  = r_tx_data;
  assign o_tx_frame = r_frame;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule
